// File: rtl/mux_sel_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_scanner
// Purpose  : Scan sequencer for an upstream 2**SEL_W:1 data-path mux. It
//            steps the mux select through every input in order and holds
//            each value for DWELL cycles. On the last cycle of each dwell
//            window it samples the mux output into a work word. When the
//            scan completes, the full word is published atomically on capt,
//            together with a one-cycle done pulse.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - scan request, sampled only while idle
//            cont   - (MUX_SCAN_CONT_EN only) chain straight into the next scan
//            y_in   - mux output being scanned
//            sel    - mux select (SEL_W bits)
//            busy   - high while a scan is in progress (SCAN and DONE)
//            done   - one-cycle pulse when capt is updated
//            capt   - captured word, bit i = y_in sampled while sel == i
// Options  : MUX_SCAN_CONT_EN adds the cont input for back-to-back scanning.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_scanner #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4   // legal range 1..255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef MUX_SCAN_CONT_EN
  input  logic                    cont,
`endif
  input  logic                    y_in,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    done,
  output logic [(2**SEL_W)-1:0]   capt
);

  localparam int               N        = 2**SEL_W;
  localparam logic [7:0]       RELOAD   = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [N-1:0]   work;
  logic [N-1:0]   work_merged;
  logic           cont_req;

`ifdef MUX_SCAN_CONT_EN
  assign cont_req = cont;
`else
  assign cont_req = 1'b0;
`endif

  // Work word with the current sample inserted. The final bit is merged
  // this way so that capt is loaded on the same edge that samples it.
  always_comb begin
    work_merged      = work;
    work_merged[sel] = y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      capt  <= '0;
      cnt   <= '0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          sel  <= '0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            cnt   <= RELOAD;
            work  <= '0;
          end else begin
            busy  <= 1'b0;
          end
        end

        SCAN: begin
          done <= 1'b0;
          if (cnt == 8'd0) begin
            // End of the dwell window: the mux has had DWELL-1 cycles to settle.
            if (sel == SEL_LAST) begin
              capt <= work_merged;
              done <= 1'b1;
              if (cont_req) begin
                // Chained scan: restart immediately with no idle gap.
                state <= SCAN;
                sel   <= '0;
                cnt   <= RELOAD;
                work  <= '0;
              end else begin
                state <= DONE;
                work  <= work_merged;
              end
            end else begin
              work <= work_merged;
              sel  <= sel + SEL_W'(1);
              cnt  <= RELOAD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DONE: begin
          // capt is already valid; finish the handshake and release the mux.
          done  <= 1'b0;
          busy  <= 1'b0;
          sel   <= '0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Sequencer that sits directly upstream of the 4:1 data-path mux. It drives the mux select and reads the mux output back.
- On a start request it steps the select through every input in order, waiting a programmable number of cycles on each one.
- It samples the mux output y into a capture word, bit index equal to the select value.
- It publishes the complete word atomically, together with a one-cycle done pulse.

Parameters:
- SEL_W, 2, select width; number of mux inputs N = 2**SEL_W.
- DWELL, 4, clock cycles spent on each select value before sampling; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- y_in  input  1  mux output being scanned.
- sel  output  SEL_W  mux select, driven to the mux S input.
- busy  output  1  high while a scan is in progress (SCAN and DONE states).
- done  output  1  one-cycle pulse when capt is updated.
- capt  output  N  captured word; bit i = y_in sampled while sel == i.

Behaviour:
- Reset (async assert, deassert sync to clk):
  - state = IDLE; sel = 0; busy = 0; done = 0; capt = 0; dwell counter = 0; internal work register = 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sel holds 0.
  - If start = 1 at a rising edge: go to SCAN, sel = 0, counter = DWELL-1, work register cleared.
- SCAN:
  - Each cycle the counter decrements.
  - When counter == 0: work[sel] <= y_in.
  - If sel == N-1: go to DONE and load capt <= work with the final bit merged (the same edge writes the last bit).
  - Otherwise: sel <= sel+1 and counter reloads DWELL-1.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle; capt is already valid.
  - Next state is IDLE; sel returns to 0.
- Sampling point:
  - y_in is sampled at the last cycle of each dwell window, giving the mux DWELL-1 cycles to settle.
  - DWELL = 1 samples in the same cycle sel changes, so the mux must be purely combinational.
- Latency:
  - Start accepted at edge k.
  - Bit i is sampled at edge k + (i+1)*DWELL.
  - done is high during the cycle after edge k + N*DWELL.
  - Start to done: N*DWELL cycles; the next start can be accepted N*DWELL+2 edges after k.
- Boundary conditions:
  - start while busy: ignored; not queued.
  - start during DONE: ignored.
  - start held high continuously: a new scan begins on the first edge in IDLE, giving back-to-back scans separated by one IDLE cycle.
  - capt changes only on the DONE-entry edge; it holds its value between scans and through IDLE.
  - Reset mid-scan: scan aborted, all outputs return to reset values immediately, no done pulse.
  - sel never exceeds N-1; there is no wrap within a scan.
- Arithmetic: counter width 8 bits, unsigned; sel increments modulo 2**SEL_W but is never incremented past N-1.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined:
  - Adds input port cont (1 bit), placed after start.
  - If cont = 1 at the edge where the final bit is sampled: done still pulses, capt updates, and the FSM goes directly to SCAN with sel = 0, counter = DWELL-1 and work cleared. busy stays high, with no IDLE gap.
  - Period between done pulses: N*DWELL cycles.
  - If cont = 0: behaviour identical to the base block.
- Not defined: port cont is absent; every scan ends in DONE then IDLE.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle -> sel = 0, busy = 0, done = 0, capt = 0 immediately, before the next clock edge.
- Basic scan: model mux with D = 4'b0110 indexed by sel; DWELL = 4; pulse start -> sel steps 0,1,2,3 at 4-cycle intervals; done pulses once 16 cycles after the start edge; capt = 4'b0110.
- Minimum dwell: DWELL = 1, D = 4'b1001 -> capt = 4'b1001, done 4 cycles after start; sel visits each value for exactly 1 cycle.
- Ignored start: start pulsed again while busy (sel = 2) -> no restart, single done, capt correct; start held high across DONE -> new scan begins one IDLE cycle later.
- Abort: rst_n low while sel = 1 -> no done; after release, capt = 0, and a fresh start with D = 4'b1111 yields capt = 4'b1111.
- MUX_SCAN_CONT_EN: cont = 1, D changes from 4'b0110 to 4'b1010 between scans -> done every 16 cycles with no idle gap; successive capt values 4'b0110 then 4'b1010.
